// File: rtl/fighter_pkg.sv
// Shared fighter definitions: action state encoding, attack kinds and default frame data.
// Imported by the sequencer, the collision block and the sprite renderer.
package fighter_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_FWD       = 3'd1,
      ST_BACK      = 3'd2,
      ST_HITSTUN   = 3'd3,
      ST_BLOCKSTUN = 3'd4,
      ST_STARTUP   = 3'd5,
      ST_ACTIVE    = 3'd6,
      ST_RECOVERY  = 3'd7
   } state_t;

   localparam logic KIND_BASIC = 1'b0;
   localparam logic KIND_DIR   = 1'b1;

   localparam int DEF_FWD_SPEED    = 3;
   localparam int DEF_BACK_SPEED   = 2;
   localparam int DEF_BAS_STARTUP  = 5;
   localparam int DEF_BAS_ACTIVE   = 2;
   localparam int DEF_BAS_RECOVERY = 16;
   localparam int DEF_DIR_STARTUP  = 4;
   localparam int DEF_DIR_ACTIVE   = 3;
   localparam int DEF_DIR_RECOVERY = 15;
   localparam int DEF_HITSTUN      = 15;
   localparam int DEF_BLOCKSTUN    = 10;

   function automatic logic is_attack(input state_t s);
      return (s == ST_STARTUP) || (s == ST_ACTIVE) || (s == ST_RECOVERY);
   endfunction

endpackage

// File: rtl/frame_phase_counter.sv
// 5-bit loadable down-counter advanced by the frame tick; used for attack phases and stun.
// It saturates at zero so an idle counter sits with zero_o high.
module frame_phase_counter (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       tick_i,
   input  logic       load_i,
   input  logic [4:0] load_val_i,
   output logic       zero_o
);

   logic [4:0] count_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         count_q <= 5'd0;
      end else if (tick_i) begin
         if (load_i)
            count_q <= load_val_i;
         else if (count_q != 5'd0)
            count_q <= count_q - 5'd1;
      end
   end

   assign zero_o = (count_q == 5'd0);

endmodule

// File: rtl/fighter_action_sequencer.sv
// Per-player action controller: button levels and collision pulses in, sprite pose out.
// frame_tick qualifies every state/x_pos update; outputs are registered and valid from the clk after each tick.
module fighter_action_sequencer
   import fighter_pkg::*;
#(
   parameter int         PLAYER_NUM   = 0,
   parameter logic [9:0] X_INIT       = 10'd100,
   parameter logic [9:0] X_MIN        = 10'd0,
   parameter logic [9:0] X_MAX        = 10'd576,
   parameter int         FWD_SPEED    = DEF_FWD_SPEED,
   parameter int         BACK_SPEED   = DEF_BACK_SPEED,
   parameter int         BAS_STARTUP  = DEF_BAS_STARTUP,
   parameter int         BAS_ACTIVE   = DEF_BAS_ACTIVE,
   parameter int         BAS_RECOVERY = DEF_BAS_RECOVERY,
   parameter int         DIR_STARTUP  = DEF_DIR_STARTUP,
   parameter int         DIR_ACTIVE   = DEF_DIR_ACTIVE,
   parameter int         DIR_RECOVERY = DEF_DIR_RECOVERY,
   parameter int         HITSTUN      = DEF_HITSTUN,
   parameter int         BLOCKSTUN    = DEF_BLOCKSTUN
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       frame_tick,
   input  logic       btn_left,
   input  logic       btn_right,
   input  logic       btn_attack,
   input  logic       hit_in,
   input  logic       block_in,
   output logic [9:0] x_pos,
   output logic [2:0] state,
   output logic       attacking,
   output logic       dir_attacking,
   output logic       busy
);

   state_t     state_q, state_d;
   logic [9:0] x_q, x_d, x_step;
   logic       kind_q, kind_d;
   logic       atk_prev_q, hit_q, blk_q;
   logic       attacking_q, dir_attacking_q, busy_q;
   logic       cnt_load, cnt_zero;
   logic [4:0] cnt_val;
   logic       hit_now, blk_now, fwd_btn, move_up;
   logic [10:0] x_ext, spd, x_up, x_dn;

   frame_phase_counter u_phase (
      .clk_i      (clk),
      .rst_i      (rst),
      .tick_i     (frame_tick),
      .load_i     (cnt_load),
      .load_val_i (cnt_val),
      .zero_o     (cnt_zero)
   );

   // A pulse arriving on the tick clk itself is consumed by that tick.
   assign hit_now = hit_q | hit_in;
   assign blk_now = blk_q | block_in;

   assign fwd_btn = (PLAYER_NUM == 0) ? btn_right : btn_left;
   assign move_up = fwd_btn ^ (PLAYER_NUM != 0);
   assign x_ext   = {1'b0, x_q};
   assign spd     = fwd_btn ? 11'(FWD_SPEED) : 11'(BACK_SPEED);
   assign x_up    = x_ext + spd;
   assign x_dn    = x_ext - spd;

   always_comb begin
      x_step = x_q;
      if (move_up)
         x_step = (x_up > {1'b0, X_MAX}) ? X_MAX : x_up[9:0];
      else
         x_step = (x_ext < ({1'b0, X_MIN} + spd)) ? X_MIN : x_dn[9:0];
   end

   always_comb begin
      state_d  = state_q;
      x_d      = x_q;
      kind_d   = kind_q;
      cnt_load = 1'b0;
      cnt_val  = 5'd0;
      if (hit_now) begin
         state_d  = ST_HITSTUN;
         cnt_load = 1'b1;
         cnt_val  = 5'(HITSTUN - 1);
      end else if (blk_now && (state_q == ST_IDLE || state_q == ST_BACK)) begin
         state_d  = ST_BLOCKSTUN;
         cnt_load = 1'b1;
         cnt_val  = 5'(BLOCKSTUN - 1);
      end else begin
         case (state_q)
            ST_IDLE, ST_FWD, ST_BACK: begin
               if (btn_attack && !atk_prev_q) begin
                  state_d  = ST_STARTUP;
                  kind_d   = (btn_left || btn_right) ? KIND_DIR : KIND_BASIC;
                  cnt_load = 1'b1;
                  cnt_val  = (kind_d == KIND_DIR) ? 5'(DIR_STARTUP - 1) : 5'(BAS_STARTUP - 1);
               end else if (btn_left ^ btn_right) begin
                  state_d = fwd_btn ? ST_FWD : ST_BACK;
                  x_d     = x_step;
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_STARTUP: if (cnt_zero) begin
               state_d  = ST_ACTIVE;
               cnt_load = 1'b1;
               cnt_val  = (kind_q == KIND_DIR) ? 5'(DIR_ACTIVE - 1) : 5'(BAS_ACTIVE - 1);
            end
            ST_ACTIVE: if (cnt_zero) begin
               state_d  = ST_RECOVERY;
               cnt_load = 1'b1;
               cnt_val  = (kind_q == KIND_DIR) ? 5'(DIR_RECOVERY - 1) : 5'(BAS_RECOVERY - 1);
            end
            default: if (cnt_zero) state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q         <= ST_IDLE;
         x_q             <= X_INIT;
         kind_q          <= KIND_BASIC;
         atk_prev_q      <= 1'b0;
         hit_q           <= 1'b0;
         blk_q           <= 1'b0;
         attacking_q     <= 1'b0;
         dir_attacking_q <= 1'b0;
         busy_q          <= 1'b0;
      end else begin
         if (hit_in)   hit_q <= 1'b1;
         if (block_in) blk_q <= 1'b1;
         if (frame_tick) begin
            hit_q           <= 1'b0;
            blk_q           <= 1'b0;
            state_q         <= state_d;
            x_q             <= x_d;
            kind_q          <= kind_d;
            atk_prev_q      <= btn_attack;
            attacking_q     <= is_attack(state_d) && (kind_d == KIND_BASIC);
            dir_attacking_q <= is_attack(state_d) && (kind_d == KIND_DIR);
            busy_q          <= (state_d != ST_IDLE) && (state_d != ST_FWD) && (state_d != ST_BACK);
         end
      end
   end

   assign x_pos         = x_q;
   assign state         = state_q;
   assign attacking     = attacking_q;
   assign dir_attacking = dir_attacking_q;
   assign busy          = busy_q;

endmodule

// File: tb/tb_fighter_action_sequencer.sv
// Bench for two sequencer instances (P1 faces right, P2 faces left) sharing inputs.
// A timeline reference model predicts each tick's pose; a monitor compares after every tick or reset.
module tb_fighter_action_sequencer;

   localparam int FWD_SPD  = 3;
   localparam int BACK_SPD = 2;
   localparam int XI       = 100;
   localparam int XHI      = 576;
   localparam int A_NONE = 0, A_ATK = 1, A_HIT = 2, A_BLK = 3;

   logic clk = 1'b0;
   logic rst, frame_tick, btn_left, btn_right, btn_attack, hit_in, block_in;
   logic [9:0] x0, x1;
   logic [2:0] st0, st1;
   logic a0, a1, d0, d1, b0, b1;

   always #5 clk = ~clk;

   fighter_action_sequencer #(.PLAYER_NUM(0)) u_p1 (
      .clk(clk), .rst(rst), .frame_tick(frame_tick), .btn_left(btn_left), .btn_right(btn_right),
      .btn_attack(btn_attack), .hit_in(hit_in), .block_in(block_in), .x_pos(x0), .state(st0),
      .attacking(a0), .dir_attacking(d0), .busy(b0));

   fighter_action_sequencer #(.PLAYER_NUM(1)) u_p2 (
      .clk(clk), .rst(rst), .frame_tick(frame_tick), .btn_left(btn_left), .btn_right(btn_right),
      .btn_attack(btn_attack), .hit_in(hit_in), .block_in(block_in), .x_pos(x1), .state(st1),
      .attacking(a1), .dir_attacking(d1), .busy(b1));

   // Reference model: an ongoing action is a timeline measured in ticks since it began.
   int   m_x[2], m_st[2], m_act[2], m_e[2], m_kind[2];
   bit   m_prev, m_hit, m_blk;
   logic [15:0] exp_q0[$], exp_q1[$];
   int   n_tests = 0, n_fail = 0;
   bit   mon_en = 1'b0;

   function automatic logic [15:0] pack(input int p);
      logic atk_b, atk_d, bsy;
      atk_b = (m_act[p] == A_ATK) && (m_kind[p] == 0);
      atk_d = (m_act[p] == A_ATK) && (m_kind[p] == 1);
      bsy   = (m_act[p] != A_NONE);
      return {10'(m_x[p]), 3'(m_st[p]), atk_b, atk_d, bsy};
   endfunction

   task automatic push_both();
      exp_q0.push_back(pack(0));
      exp_q1.push_back(pack(1));
   endtask

   task automatic model_reset();
      for (int p = 0; p < 2; p++) begin
         m_x[p] = XI; m_st[p] = 0; m_act[p] = A_NONE; m_e[p] = 0; m_kind[p] = 0;
      end
      m_prev = 0; m_hit = 0; m_blk = 0;
   endtask

   task automatic model_step(input bit l, input bit r, input bit a);
      int s_len, a_len, r_len, nx, spd;
      bit fwd, up;
      for (int p = 0; p < 2; p++) begin
         if (m_hit) begin
            m_act[p] = A_HIT; m_e[p] = 0;
         end else if (m_blk && (m_st[p] == 0 || m_st[p] == 2)) begin
            m_act[p] = A_BLK; m_e[p] = 0;
         end else if (m_act[p] != A_NONE) begin
            m_e[p]++;
         end else if (a && !m_prev) begin
            m_act[p] = A_ATK; m_e[p] = 0; m_kind[p] = (l || r) ? 1 : 0;
         end else if (l != r) begin
            fwd = (p == 0) ? r : l;
            m_st[p] = fwd ? 1 : 2;
            spd = fwd ? FWD_SPD : BACK_SPD;
            up = (p == 0) ? fwd : !fwd;
            nx = up ? m_x[p] + spd : m_x[p] - spd;
            if (nx > XHI) nx = XHI;
            if (nx < 0) nx = 0;
            m_x[p] = nx;
         end else begin
            m_st[p] = 0;
         end
         s_len = m_kind[p] ? 4 : 5;
         a_len = m_kind[p] ? 3 : 2;
         r_len = m_kind[p] ? 15 : 16;
         case (m_act[p])
            A_ATK: begin
               if (m_e[p] < s_len) m_st[p] = 5;
               else if (m_e[p] < s_len + a_len) m_st[p] = 6;
               else if (m_e[p] < s_len + a_len + r_len) m_st[p] = 7;
               else begin m_st[p] = 0; m_act[p] = A_NONE; end
            end
            A_HIT: if (m_e[p] < 15) m_st[p] = 3; else begin m_st[p] = 0; m_act[p] = A_NONE; end
            A_BLK: if (m_e[p] < 10) m_st[p] = 4; else begin m_st[p] = 0; m_act[p] = A_NONE; end
            default: ;
         endcase
      end
      m_prev = a; m_hit = 0; m_blk = 0;
   endtask

   task automatic do_tick(input bit l, input bit r, input bit a);
      @(negedge clk);
      btn_left = l; btn_right = r; btn_attack = a; frame_tick = 1'b1;
      model_step(l, r, a);
      push_both();
      @(negedge clk);
      frame_tick = 1'b0;
      @(negedge clk);
   endtask

   task automatic run(input int n, input bit l, input bit r, input bit a);
      repeat (n) do_tick(l, r, a);
   endtask

   task automatic pulse(input bit h, input bit b);
      @(negedge clk);
      hit_in = h; block_in = b;
      if (h) m_hit = 1;
      if (b) m_blk = 1;
      @(negedge clk);
      hit_in = 1'b0; block_in = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      model_reset();
      push_both();
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic check_one(input int p, input logic [15:0] act_v);
      logic [15:0] e;
      n_tests++;
      if ((p == 0 && exp_q0.size() == 0) || (p == 1 && exp_q1.size() == 0)) begin
         n_fail++;
         $display("FAIL p%0d_output: got %h with no expected value queued", p + 1, act_v);
      end else begin
         e = (p == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
         if (act_v !== e) begin
            n_fail++;
            $display("FAIL p%0d_output @%0t: got x=%0d st=%0d atk=%b dir=%b busy=%b, want x=%0d st=%0d atk=%b dir=%b busy=%b",
                     p + 1, $time, act_v[15:6], act_v[5:3], act_v[2], act_v[1], act_v[0],
                     e[15:6], e[5:3], e[2], e[1], e[0]);
         end
      end
   endtask

   initial begin
      forever begin
         @(posedge clk);
         if (mon_en && (rst || frame_tick)) begin
            @(negedge clk);
            check_one(0, {x0, st0, a0, d0, b0});
            check_one(1, {x1, st1, a1, d1, b1});
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; frame_tick = 1'b0; btn_left = 1'b0; btn_right = 1'b0;
      btn_attack = 1'b0; hit_in = 1'b0; block_in = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      rst = 1'b0;
      mon_en = 1'b1;
      do_reset();

      run(10, 0, 1, 0);                      // walk: P1 forward, P2 back
      run(2, 0, 0, 0);
      do_tick(0, 0, 1); run(25, 0, 0, 0);    // basic attack
      do_tick(0, 1, 1); run(24, 0, 1, 0);    // directional attack, held direction frozen
      run(1, 0, 0, 0);
      do_tick(0, 0, 1); run(5, 0, 0, 0);     // into ACTIVE
      pulse(1, 0); run(17, 0, 0, 0);         // hit cancels the attack
      run(70, 1, 0, 0);                      // both clamp at the left edge
      run(200, 0, 1, 0);                     // P1 clamps at the right edge
      run(2, 1, 0, 0);
      pulse(1, 1); run(17, 1, 0, 0);         // hit and block together: hit wins
      pulse(0, 1); run(12, 1, 0, 0);         // block: P1 in BACK stuns, P2 in FWD ignores
      do_tick(0, 0, 1); run(10, 0, 0, 0);    // into RECOVERY
      do_reset();
      run(3, 0, 1, 0);

      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(7) == 0) pulse(1'($urandom_range(1)), 1'($urandom_range(1)));
         if ($urandom_range(96) == 0) do_reset();
         do_tick(1'($urandom_range(1)), 1'($urandom_range(1)), ($urandom_range(3) == 0));
      end

      repeat (4) @(negedge clk);
      n_tests++;
      if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d/%0d expected values left unchecked, want 0/0", exp_q0.size(), exp_q1.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/fighter_action_sequencer.md
Name: fighter_action_sequencer

Overview:
- Per-player action controller that turns debounced button levels into the pose and attack signals the character sprite renderer consumes: x_pos, attacking, dir_attacking and the 3-bit state.
- Advances only on a 60 Hz frame tick and implements movement, attack phase timing (startup/active/recovery) and hit/block stun from collision feedback.
- One instance per player; the game top level instantiates two.

Parameters:
- PLAYER_NUM, 0, facing/forward direction; 0 faces right (forward = +x), 1 faces left (forward = -x).
- X_INIT, 10'd100, x_pos after reset.
- X_MIN, 10'd0, leftmost legal x_pos.
- X_MAX, 10'd576, rightmost legal x_pos (640 - 64 sprite width).
- FWD_SPEED, 3, pixels per frame moving forward.
- BACK_SPEED, 2, pixels per frame moving backward.
- BAS_STARTUP / BAS_ACTIVE / BAS_RECOVERY, 5 / 2 / 16, basic attack phase lengths in frames.
- DIR_STARTUP / DIR_ACTIVE / DIR_RECOVERY, 4 / 3 / 15, directional attack phase lengths in frames.
- HITSTUN, 15, frames of hitstun.
- BLOCKSTUN, 10, frames of blockstun.

Ports:
- clk  in  1  system pixel clock.
- rst  in  1  synchronous reset, active-high.
- frame_tick  in  1  one-clk pulse per video frame.
- btn_left  in  1  level, debounced.
- btn_right  in  1  level, debounced.
- btn_attack  in  1  level, debounced.
- hit_in  in  1  pulse: opponent's active hitbox struck this player's hurtbox unblocked.
- block_in  in  1  pulse: strike was blocked.
- x_pos  out  10  sprite top-left X.
- state  out  3  encoded action state.
- attacking  out  1  basic attack in progress.
- dir_attacking  out  1  directional attack in progress.
- busy  out  1  player not actionable (any attack or stun state).

Behaviour:
- State encoding (shared package):
  - 0 IDLE, 1 FWD, 2 BACK, 3 HITSTUN, 4 BLOCKSTUN, 5 STARTUP, 6 ACTIVE, 7 RECOVERY.
- Reset (sync, takes priority over everything): x_pos=X_INIT, state=IDLE, attacking=0, dir_attacking=0, busy=0, frame counter=0, attack-kind register=0, pending hit/block latches cleared.
- Collision latches:
  - hit_in and block_in may arrive on any clk; each sets a sticky latch.
  - Latches are consumed and cleared on the next frame_tick.
  - If hit and block are latched together, hit wins.
- All state, counter and x_pos updates occur only on clk edges where frame_tick=1. Outputs are registered and change the clk after the tick.
- Per-tick priority:
  1. Latched hit → HITSTUN with counter=HITSTUN-1, from any state including attacks.
  2. Latched block → BLOCKSTUN with counter=BLOCKSTUN-1, only from BACK or IDLE; otherwise ignored.
  3. Normal transitions below.
- Normal transitions from actionable states (IDLE/FWD/BACK), evaluated in this order:
  - btn_attack rising edge (sampled at the previous tick vs this tick) → STARTUP.
    - If a direction button is held, attack kind = directional; otherwise basic.
    - Counter = STARTUP-1 of that kind.
  - Exactly one direction held → FWD or BACK, mapped by PLAYER_NUM.
  - Both or neither held → IDLE.
- Phase countdown (STARTUP, ACTIVE, RECOVERY, HITSTUN, BLOCKSTUN):
  - Counter decrements each tick.
  - At 0: STARTUP→ACTIVE, ACTIVE→RECOVERY (each loads the next phase length-1 for the latched kind); RECOVERY, HITSTUN and BLOCKSTUN → IDLE.
  - Button input is ignored in these states; attack presses are not buffered.
- attacking = kind basic AND state∈{5,6,7}. dir_attacking = kind directional AND state∈{5,6,7}. Never both set.
- busy = state∈{3,4,5,6,7}.
- Movement:
  - FWD adds/subtracts FWD_SPEED per tick; BACK applies BACK_SPEED opposite to forward.
  - Unsigned 11-bit intermediate; result is clamped to [X_MIN, X_MAX] with no wrap.
  - Movement applies on the tick the state is FWD or BACK, using the new state's direction.
  - No movement in other states.
- Mid-operation reset: rst during any phase returns to reset values on that clk edge; pending latches are lost.
- A hit during ACTIVE cancels the attack immediately; attacking/dir_attacking drop on the tick's output update.

Decomposition:
- Package fighter_pkg:
  - 3-bit state localparams (ST_IDLE..ST_RECOVERY).
  - Attack-kind constant.
  - Default frame-data values, shared with the collision and renderer blocks.
- Sub-module frame_phase_counter: 5-bit loadable down-counter with tick enable and zero flag. Reused for stun and attack phases.

Test Plan:
- P1, idle, hold btn_right 10 ticks → x_pos 100→130, state=1 throughout; release → state=0 and x_pos holds at 130.
- Tap btn_attack with no direction → state 5 for 5 ticks, 6 for 2, 7 for 16, then 0. attacking=1 for all 23 ticks, dir_attacking=0.
- Hold btn_right and tap btn_attack (P1) → dir_attacking=1. Phases run 4/3/15; x_pos is frozen during the attack.
- hit_in pulse mid-ACTIVE → next tick state=3 and attacking=0; after 15 ticks state=0.
- P2 at x=1, hold btn_right (back = +x for P2) versus P2 at x=1 holding btn_left (forward = -x) → second case clamps to X_MIN=0 with no wrap. Likewise P1 at 575 moving forward clamps to 576.
- hit_in and block_in latched in the same frame while in BACK → HITSTUN. rst during RECOVERY → state=0, x_pos=X_INIT on the next clk.
